// File: rtl/pr_request_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pr_request_ctrl
// Brief    : Request collection and grant handshake around an external 8-bit
//            priority encoder. Sticky pending register, masked pending vector
//            to the encoder, one-hot grant offered over valid/ack, service
//            interval supervised by a timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
module pr_request_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    output logic [7:0] pend,
    input  logic [7:0] sel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    input  logic       gnt_ack,
    input  logic       done,
    output logic       busy,
    output logic       timeout,
    output logic       sel_err,
    output logic [7:0] gnt_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Timer value of the final SERVICE cycle; reaching it without done aborts.
    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    // Binary position of the (single) set bit of a one-hot vector.
    function automatic logic [2:0] f_encode(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_t     state_q,     state_d;
    logic [7:0] pend_q,      pend_d;
    logic [7:0] gnt_q,       gnt_d;
    logic [2:0] gnt_idx_q,   gnt_idx_d;
    logic [7:0] timer_q,     timer_d;
    logic       timeout_q,   timeout_d;
    logic       sel_err_q,   sel_err_d;
    logic [7:0] gnt_count_q, gnt_count_d;

    logic       w_ack;
    logic [7:0] w_clr;
    logic       w_sel_multi;
    logic       w_sel_onehot;

    // Accepted handshake and the pending bit it retires.
    assign w_ack = (state_q == ST_OFFER) && gnt_ack;
    assign w_clr = w_ack ? gnt_q : 8'h00;

    // sel & (sel-1) is nonzero exactly when two or more bits are set.
    assign w_sel_multi  = |(sel & (sel - 8'd1));
    assign w_sel_onehot = (sel != 8'h00) && !w_sel_multi;

    // Sticky pending: a new request on the bit being cleared wins.
    always_comb begin
        pend_d = (pend_q & ~w_clr) | req;
    end

    // Grant handshake and service supervision.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        timer_d     = timer_q;
        timeout_d   = 1'b0;
        sel_err_d   = sel_err_q;
        gnt_count_d = gnt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_sel_onehot) begin
                    gnt_d     = sel;
                    gnt_idx_d = f_encode(sel);
                    state_d   = ST_OFFER;
                end else if (w_sel_multi) begin
                    // Malformed encoder output: flag it and refuse to grant.
                    sel_err_d = 1'b1;
                end
            end

            ST_OFFER: begin
                // Grant is frozen here; mask/req changes only affect pending.
                if (gnt_ack) begin
                    gnt_count_d = gnt_count_q + 8'd1;
                    timer_d     = 8'd0;
                    state_d     = ST_SERVICE;
                end
            end

            ST_SERVICE: begin
                if (done) begin
                    // done takes priority over an abort in the same cycle.
                    state_d   = ST_IDLE;
                    gnt_d     = 8'h00;
                    gnt_idx_d = 3'd0;
                    timer_d   = 8'd0;
                end else if (timer_q == c_timer_last) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    gnt_d     = 8'h00;
                    gnt_idx_d = 3'd0;
                    timer_d   = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                gnt_d     = 8'h00;
                gnt_idx_d = 3'd0;
                timer_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 8'h00;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            timer_q     <= 8'd0;
            timeout_q   <= 1'b0;
            sel_err_q   <= 1'b0;
            gnt_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            sel_err_q   <= sel_err_d;
            gnt_count_q <= gnt_count_d;
        end
    end

    assign pend      = pend_q & ~mask;
    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == ST_OFFER);
    assign busy      = (state_q == ST_SERVICE);
    assign timeout   = timeout_q;
    assign sel_err   = sel_err_q;
    assign gnt_count = gnt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pr_request_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pr_request_ctrl
// Brief    : Scoreboard bench for pr_request_ctrl. The driver predicts each
//            grant from a pending-set model and queues it; a monitor pops and
//            compares whenever a new grant is offered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pr_request_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, mask, pend, sel, gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid, gnt_ack, done, busy, timeout, sel_err;
    logic [7:0] gnt_count;

    logic       force_en;
    logic [7:0] force_val;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_pend;    // model of the pending set
    logic [7:0] m_count;   // model of accepted grants, mod 256
    logic [7:0] m_last_g;  // grant the model expects to be on offer

    always #5 clk = ~clk;

    pr_request_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .pend      (pend),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_ack   (gnt_ack),
        .done      (done),
        .busy      (busy),
        .timeout   (timeout),
        .sel_err   (sel_err),
        .gnt_count (gnt_count)
    );

    function automatic int hi_bit(input logic [7:0] v);
        int b;
        b = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) b = i;
        end
        return b;
    endfunction

    // Behavioural priority encoder feeding sel, with an override for fault injection.
    always_comb begin
        sel = 8'h00;
        if (force_en) sel = force_val;
        else if (pend != 8'h00) sel = 8'(1 << hi_bit(pend));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each newly offered grant with the head of the queue.
    initial begin
        logic prev_valid;
        logic prev_to;
        exp_t cur;
        prev_valid = 1'b0;
        prev_to    = 1'b0;
        cur        = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_to    = 1'b0;
            end else begin
                if (gnt_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got gnt %0h expected none", gnt);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_gnt", gnt, cur.g);
                        chk("grant_idx", gnt_idx, cur.idx);
                        chk("grant_count", gnt_count, cur.cnt);
                    end
                end else if (gnt_valid) begin
                    chk("gnt_stable", gnt, cur.g);
                    chk("gnt_idx_stable", gnt_idx, cur.idx);
                end
                if (timeout) chk("timeout_one_cycle", prev_to, 0);
                prev_valid = gnt_valid;
                prev_to    = timeout;
            end
        end
    end

    // Queue the grant the encoder should produce from the visible pending set.
    task automatic push_next(output bit pushed);
        logic [7:0] e;
        int         b;
        exp_t       x;
        e      = m_pend & ~mask;
        pushed = 1'b0;
        if (e != 8'h00) begin
            b        = hi_bit(e);
            x.g      = 8'(1 << b);
            x.idx    = 3'(b);
            x.cnt    = m_count;
            m_last_g = x.g;
            exp_q.push_back(x);
            pushed   = 1'b1;
        end
    endtask

    task automatic wait_valid(input int exp_lat);
        int n = 0;
        while (!gnt_valid && n < 40) begin
            step();
            n++;
        end
        chk("grant_latency", n, exp_lat);
    endtask

    // Pulse req in an idle cycle with nothing visible pending.
    task automatic inject(input logic [7:0] r);
        bit got;
        req    = r;
        m_pend = m_pend | r;
        push_next(got);
        step();
        req = 8'h00;
        wait_valid(1);
    endtask

    // Handle one offered grant: hold, ack, then done or let it time out.
    task automatic serve(input int hold, input logic [7:0] hold_req, input logic [7:0] hold_mask,
                         input logic [7:0] ack_req, input logic [7:0] post_mask, input int done_cyc);
        int n;
        for (int i = 0; i < hold; i++) begin
            req    = hold_req;
            mask   = hold_mask;
            m_pend = m_pend | hold_req;
            step();
        end
        chk("offer_held", gnt_valid, 1);
        req     = ack_req;
        mask    = post_mask;
        gnt_ack = 1'b1;
        m_pend  = (m_pend & ~m_last_g) | ack_req;
        m_count = m_count + 8'd1;
        step();
        gnt_ack = 1'b0;
        req     = 8'h00;
        chk("service_busy", busy, 1);
        chk("service_no_valid", gnt_valid, 0);
        chk("service_pend", pend, m_pend & ~mask);
        chk("service_count", gnt_count, m_count);
        if (done_cyc > 0) begin
            for (int i = 1; i < done_cyc; i++) step();
            chk("busy_before_done", busy, 1);
            done = 1'b1;
            step();
            done = 1'b0;
            chk("idle_after_done", busy, 0);
            chk("no_timeout_on_done", timeout, 0);
        end else begin
            n = 0;
            while (busy && n < 40) begin
                n++;
                step();
            end
            chk("busy_cycles", n, TIMEOUT);
            chk("timeout_pulse", timeout, 1);
        end
    endtask

    function automatic logic [7:0] rand_mask();
        logic [7:0] m;
        m = 8'($urandom);
        if (m == 8'hFF) m = 8'h7F;
        return m;
    endfunction

    task automatic random_txn();
        bit         got;
        int         b;
        int         dc;
        logic [7:0] r;
        if (!gnt_valid) begin
            b = $urandom_range(0, 7);
            while (mask[b]) b = $urandom_range(0, 7);
            r = 8'($urandom) | 8'(1 << b);
            inject(r);
        end
        dc = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
        serve($urandom_range(0, 3),
              8'($urandom) & 8'($urandom) & 8'($urandom),
              rand_mask(),
              8'($urandom) & 8'($urandom) & 8'($urandom),
              rand_mask(), dc);
        push_next(got);
        if (got) wait_valid(1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pend"},      pend, 0);
        chk({tag, "_gnt"},       gnt, 0);
        chk({tag, "_gnt_idx"},   gnt_idx, 0);
        chk({tag, "_gnt_valid"}, gnt_valid, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_timeout"},   timeout, 0);
        chk({tag, "_sel_err"},   sel_err, 0);
        chk({tag, "_gnt_count"}, gnt_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         got;
        logic [7:0] cnt0;
        rst = 1'b1; req = 8'h00; mask = 8'h00; gnt_ack = 1'b0; done = 1'b0;
        force_en = 1'b0; force_val = 8'h00;
        m_pend = 8'h00; m_count = 8'h00; m_last_g = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Quiet period: nothing pending, nothing offered.
        for (int i = 0; i < 10; i++) begin
            chk("quiet_pend", pend, 0);
            chk("quiet_valid", gnt_valid, 0);
            chk("quiet_count", gnt_count, 0);
            step();
        end

        // Three requests served in priority order.
        inject(8'b1001_0100);
        for (int k = 0; k < 3; k++) begin
            serve(0, 8'h00, 8'h00, 8'h00, 8'h00, 3);
            push_next(got);
            if (got) wait_valid(1);
        end
        chk("burst_count", gnt_count, 3);
        chk("burst_pend", pend, 0);
        step();
        chk("burst_no_more", gnt_valid, 0);

        // Mask/req changes during OFFER must not alter the grant.
        inject(8'h10);
        serve(2, 8'h80, 8'h10, 8'h00, 8'h00, 3);
        push_next(got);
        if (got) wait_valid(1);
        serve(0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        push_next(got);
        if (got) wait_valid(1);

        // Request held through its own ack stays pending and is re-granted.
        inject(8'h08);
        serve(1, 8'h08, 8'h00, 8'h08, 8'h00, 4);
        push_next(got);
        if (got) wait_valid(1);
        serve(0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        push_next(got);
        if (got) wait_valid(1);

        // Timeout abort, then done on the last allowed cycle.
        inject(8'h01);
        serve(0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        push_next(got);
        if (got) wait_valid(1);
        step();
        chk("timeout_cleared", timeout, 0);
        inject(8'h02);
        serve(0, 8'h00, 8'h00, 8'h00, 8'h00, TIMEOUT);
        push_next(got);
        if (got) wait_valid(1);

        // Malformed encoder output in IDLE.
        force_en  = 1'b1;
        force_val = 8'h03;
        step();
        force_en = 1'b0;
        chk("sel_err_set", sel_err, 1);
        chk("sel_err_no_grant", gnt_valid, 0);
        step();
        chk("sel_err_no_grant2", gnt_valid, 0);
        chk("sel_err_sticky", sel_err, 1);

        // 256 accepted grants bring the counter back around.
        cnt0 = m_count;
        repeat (256) random_txn();
        chk("gnt_count_wrap", gnt_count, cnt0);
        chk("sel_err_still_set", sel_err, 1);

        // Reset in the middle of a service interval.
        if (!gnt_valid) inject(8'h40);
        gnt_ack = 1'b1;
        step();
        gnt_ack = 1'b0;
        chk("pre_reset_busy", busy, 1);
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_pend = 8'h00; m_count = 8'h00;
        check_reset_state("midreset");
        step();
        chk("midreset_dropped", gnt_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
